// File: rtl/sig_capture_pkg.sv
// Shared constants for the signal sample memory: sweep bases, depth and widths.
// The display read path uses the same constants for its addresses.
package sig_capture_pkg;

  localparam int unsigned ADDR_WIDTH   = 12;
  localparam int unsigned DATA_WIDTH   = 32;
  localparam int unsigned SAMPLE_WIDTH = 12;
  localparam int unsigned DECIM_WIDTH  = 8;
  localparam int unsigned DEPTH        = 320;
  localparam int unsigned PTR_WIDTH    = $clog2(DEPTH);

  localparam logic [ADDR_WIDTH-1:0] CH0_BASE = 12'h559;
  localparam logic [ADDR_WIDTH-1:0] CH1_BASE = 12'h6AD;

  // Identifies the channel that won the most recent write slot.
  typedef enum logic {
    ChanZero = 1'b0,
    ChanOne  = 1'b1
  } chan_e;

endpackage

// File: rtl/sig_channel_stage.sv
// One acquisition channel: decimation counter, single-entry hold register,
// sticky overflow flag and circular sweep pointer.
module sig_channel_stage
  import sig_capture_pkg::*;
#(
  parameter logic [ADDR_WIDTH-1:0] BASE = CH0_BASE
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    valid,
  input  logic [SAMPLE_WIDTH-1:0] sample,
  input  logic [DECIM_WIDTH-1:0]  decim,
  input  logic                    grant,
  input  logic                    clear_ovf,
  output logic                    full,
  output logic [SAMPLE_WIDTH-1:0] hold,
  output logic [ADDR_WIDTH-1:0]   addr,
  output logic                    last,
  output logic                    ovf
);

  logic [DECIM_WIDTH-1:0]  cnt_q, cnt_d;
  logic                    full_q, full_d;
  logic [SAMPLE_WIDTH-1:0] hold_q, hold_d;
  logic                    ovf_q, ovf_d;
  logic [PTR_WIDTH-1:0]    ptr_q, ptr_d;
  logic                    accept;

  always_comb begin
    accept = valid && (cnt_q == '0);
    cnt_d  = cnt_q;
    full_d = full_q;
    hold_d = hold_q;
    ovf_d  = ovf_q;
    ptr_d  = ptr_q;

    // decim is only sampled on reload, so a change waits for the current count.
    if (valid) begin
      cnt_d = accept ? decim : cnt_q - 1'b1;
    end

    if (grant) begin
      full_d = 1'b0;
      ptr_d  = (ptr_q == PTR_WIDTH'(DEPTH - 1)) ? '0 : ptr_q + 1'b1;
    end

    if (clear_ovf) begin
      ovf_d = 1'b0;
    end

    // A hold being drained this cycle can take the new sample without loss.
    if (accept) begin
      if (!full_q || grant) begin
        hold_d = sample;
        full_d = 1'b1;
      end else begin
        ovf_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      full_q <= 1'b0;
      hold_q <= '0;
      ovf_q  <= 1'b0;
      ptr_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      full_q <= full_d;
      hold_q <= hold_d;
      ovf_q  <= ovf_d;
      ptr_q  <= ptr_d;
    end
  end

  assign full = full_q;
  assign hold = hold_q;
  assign addr = BASE + ADDR_WIDTH'(ptr_q);
  assign last = (ptr_q == PTR_WIDTH'(DEPTH - 1));
  assign ovf  = ovf_q;

endmodule

// File: rtl/sig_capture_writer.sv
// Writes two decimated sample streams into circular sweeps of the shared signal
// RAM through its single write port, using a round-robin arbiter.
module sig_capture_writer
  import sig_capture_pkg::*;
(
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ch0_valid,
  input  logic [SAMPLE_WIDTH-1:0] ch0_sample,
  input  logic                    ch1_valid,
  input  logic [SAMPLE_WIDTH-1:0] ch1_sample,
  input  logic [DECIM_WIDTH-1:0]  decim,
  input  logic                    freeze,
  input  logic                    clear_ovf,
  output logic                    wr_en,
  output logic [ADDR_WIDTH-1:0]   wr_addr,
  output logic [DATA_WIDTH-1:0]   wr_data,
  output logic                    ch0_wrap,
  output logic                    ch1_wrap,
  output logic                    ch0_ovf,
  output logic                    ch1_ovf
);

  localparam int unsigned PadWidth = DATA_WIDTH - SAMPLE_WIDTH;

  logic                    full0, full1, last0, last1, gnt0, gnt1;
  logic [SAMPLE_WIDTH-1:0] hold0, hold1;
  logic [ADDR_WIDTH-1:0]   addr0, addr1;

  chan_e                   last_q, last_d;
  logic                    wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
  logic                    wrap0_q, wrap0_d, wrap1_q, wrap1_d;

  sig_channel_stage #(
    .BASE (CH0_BASE)
  ) u_ch0 (
    .clock     (clock),
    .reset     (reset),
    .valid     (ch0_valid),
    .sample    (ch0_sample),
    .decim     (decim),
    .grant     (gnt0),
    .clear_ovf (clear_ovf),
    .full      (full0),
    .hold      (hold0),
    .addr      (addr0),
    .last      (last0),
    .ovf       (ch0_ovf)
  );

  sig_channel_stage #(
    .BASE (CH1_BASE)
  ) u_ch1 (
    .clock     (clock),
    .reset     (reset),
    .valid     (ch1_valid),
    .sample    (ch1_sample),
    .decim     (decim),
    .grant     (gnt1),
    .clear_ovf (clear_ovf),
    .full      (full1),
    .hold      (hold1),
    .addr      (addr1),
    .last      (last1),
    .ovf       (ch1_ovf)
  );

  always_comb begin
    // On contention the channel not served last wins.
    gnt0      = full0 && !freeze && (!full1 || (last_q == ChanOne));
    gnt1      = full1 && !freeze && !gnt0;
    last_d    = last_q;
    wr_en_d   = gnt0 || gnt1;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wrap0_d   = gnt0 && last0;
    wrap1_d   = gnt1 && last1;
    if (gnt0) begin
      last_d    = ChanZero;
      wr_addr_d = addr0;
      wr_data_d = {{PadWidth{1'b0}}, hold0};
    end else if (gnt1) begin
      last_d    = ChanOne;
      wr_addr_d = addr1;
      wr_data_d = {{PadWidth{1'b0}}, hold1};
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_q    <= ChanOne;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wrap0_q   <= 1'b0;
      wrap1_q   <= 1'b0;
    end else begin
      last_q    <= last_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wrap0_q   <= wrap0_d;
      wrap1_q   <= wrap1_d;
    end
  end

  assign wr_en    = wr_en_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign ch0_wrap = wrap0_q;
  assign ch1_wrap = wrap1_q;

endmodule

// File: tb/tb_sig_capture_writer.sv
// Self-checking bench for sig_capture_writer: directed vector table, directed
// corner sequences and randomized traffic against a behavioural model.
module tb_sig_capture_writer;

  logic        clock = 1'b0;
  logic        reset;
  logic        ch0_valid, ch1_valid, freeze, clear_ovf;
  logic [11:0] ch0_sample, ch1_sample;
  logic [7:0]  decim;
  logic        wr_en, ch0_wrap, ch1_wrap, ch0_ovf, ch1_ovf;
  logic [11:0] wr_addr;
  logic [31:0] wr_data;

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  sig_capture_writer dut (
    .clock      (clock),
    .reset      (reset),
    .ch0_valid  (ch0_valid),
    .ch0_sample (ch0_sample),
    .ch1_valid  (ch1_valid),
    .ch1_sample (ch1_sample),
    .decim      (decim),
    .freeze     (freeze),
    .clear_ovf  (clear_ovf),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .ch0_wrap   (ch0_wrap),
    .ch1_wrap   (ch1_wrap),
    .ch0_ovf    (ch0_ovf),
    .ch1_ovf    (ch1_ovf)
  );

  // Behavioural model: each channel keeps a skip count, a one-deep mailbox and
  // a sweep position; one mailbox is drained per cycle.
  int   m_cnt[2];
  logic m_full[2];
  int   m_hold[2];
  int   m_ptr[2];
  logic m_ovf[2];
  int   m_last;
  logic m_en;
  int   m_addr, m_data;
  logic m_wrap[2];

  function automatic int base_of(input int c);
    return (c == 0) ? 'h559 : 'h6AD;
  endfunction

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_cnt[c] = 0; m_full[c] = 0; m_hold[c] = 0; m_ptr[c] = 0;
      m_ovf[c] = 0; m_wrap[c] = 0;
    end
    m_last = 1; m_en = 0; m_addr = 0; m_data = 0;
  endtask

  task automatic model_edge();
    int   g;
    logic v[2];
    int   s[2];
    if (!reset) begin
      model_reset();
      return;
    end
    v[0] = ch0_valid; v[1] = ch1_valid;
    s[0] = int'(ch0_sample); s[1] = int'(ch1_sample);
    g = -1;
    if (!freeze) begin
      if (m_full[0] && m_full[1]) g = 1 - m_last;
      else if (m_full[0])         g = 0;
      else if (m_full[1])         g = 1;
    end
    m_wrap[0] = 0; m_wrap[1] = 0;
    m_en = (g >= 0);
    if (g >= 0) begin
      m_addr    = base_of(g) + m_ptr[g];
      m_data    = m_hold[g];
      m_wrap[g] = (m_ptr[g] == 319);
      m_full[g] = 0;
      m_ptr[g]  = (m_ptr[g] + 1) % 320;
      m_last    = g;
    end
    if (clear_ovf) begin
      m_ovf[0] = 0; m_ovf[1] = 0;
    end
    for (int c = 0; c < 2; c++) begin
      if (v[c]) begin
        if (m_cnt[c] == 0) begin
          m_cnt[c] = int'(decim);
          if (m_full[c]) m_ovf[c] = 1;
          else begin
            m_full[c] = 1;
            m_hold[c] = s[c];
          end
        end else begin
          m_cnt[c] = m_cnt[c] - 1;
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, got, exp, $time);
    end
  endtask

  task automatic check_model();
    checks++;
    if (wr_en !== m_en || (m_en && (wr_addr !== 12'(m_addr) || wr_data !== 32'(m_data)))
        || ch0_wrap !== m_wrap[0] || ch1_wrap !== m_wrap[1]
        || ch0_ovf !== m_ovf[0] || ch1_ovf !== m_ovf[1]) begin
      failures++;
      $display("FAIL model got en=%b addr=%h data=%h wrap=%b%b ovf=%b%b expected en=%b addr=%h data=%h wrap=%b%b ovf=%b%b at %0t",
               wr_en, wr_addr, wr_data, ch0_wrap, ch1_wrap, ch0_ovf, ch1_ovf,
               m_en, 12'(m_addr), 32'(m_data), m_wrap[0], m_wrap[1], m_ovf[0], m_ovf[1], $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    check_model();
  endtask

  task automatic idle();
    ch0_valid = 0; ch1_valid = 0; ch0_sample = 0; ch1_sample = 0;
    freeze = 0; clear_ovf = 0;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1;
    idle();
    decim = 0;
    reset = 0;
    #1;
    model_reset();
    check("rst_wr_en", 32'(wr_en), 0);
    check("rst_wr_addr", 32'(wr_addr), 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_flags", {28'd0, ch0_wrap, ch1_wrap, ch0_ovf, ch1_ovf}, 0);
    @(posedge clock);
    #1;
    reset = 1;
  endtask

  typedef struct {
    logic        v0;
    logic [11:0] s0;
    logic        v1;
    logic [11:0] s1;
    logic [7:0]  dec;
    logic        frz;
    logic        clr;
    logic        en;
    logic [11:0] addr;
    logic [11:0] data;
    logic        ovf0;
    logic        ovf1;
  } vec_t;

  function automatic vec_t mk(input logic v0, input logic [11:0] s0, input logic v1,
                              input logic [11:0] s1, input logic [7:0] dec, input logic frz,
                              input logic clr, input logic en, input logic [11:0] addr,
                              input logic [11:0] data, input logic ovf0, input logic ovf1);
    vec_t r;
    r.v0 = v0; r.s0 = s0; r.v1 = v1; r.s1 = s1; r.dec = dec; r.frz = frz; r.clr = clr;
    r.en = en; r.addr = addr; r.data = data; r.ovf0 = ovf0; r.ovf1 = ovf1;
    return r;
  endfunction

  vec_t tbl[16];
  int   wraps, nw;

  initial begin
    reset = 1;
    idle();
    decim = 0;
    do_reset();

    //            v0 s0      v1 s1      dec frz clr  en addr     data     o0 o1
    tbl[0]  = mk(1, 12'h011, 0, 12'h000, 0, 0, 0,  0, 12'h000, 12'h000, 0, 0);
    tbl[1]  = mk(0, 12'h000, 1, 12'h022, 0, 0, 0,  1, 12'h559, 12'h011, 0, 0);
    tbl[2]  = mk(0, 12'h000, 0, 12'h000, 0, 0, 0,  1, 12'h6AD, 12'h022, 0, 0);
    tbl[3]  = mk(0, 12'h000, 0, 12'h000, 0, 0, 0,  0, 12'h000, 12'h000, 0, 0);
    tbl[4]  = mk(1, 12'h033, 1, 12'h044, 0, 0, 0,  0, 12'h000, 12'h000, 0, 0);
    tbl[5]  = mk(0, 12'h000, 0, 12'h000, 0, 0, 0,  1, 12'h55A, 12'h033, 0, 0);
    tbl[6]  = mk(0, 12'h000, 0, 12'h000, 0, 0, 0,  1, 12'h6AE, 12'h044, 0, 0);
    tbl[7]  = mk(1, 12'h055, 0, 12'h000, 0, 1, 0,  0, 12'h000, 12'h000, 0, 0);
    tbl[8]  = mk(1, 12'h066, 0, 12'h000, 0, 1, 0,  0, 12'h000, 12'h000, 1, 0);
    tbl[9]  = mk(0, 12'h000, 0, 12'h000, 0, 0, 1,  1, 12'h55B, 12'h055, 0, 0);
    tbl[10] = mk(0, 12'h000, 0, 12'h000, 0, 0, 0,  0, 12'h000, 12'h000, 0, 0);
    tbl[11] = mk(1, 12'h077, 0, 12'h000, 2, 0, 0,  0, 12'h000, 12'h000, 0, 0);
    tbl[12] = mk(1, 12'h088, 0, 12'h000, 0, 0, 0,  1, 12'h55C, 12'h077, 0, 0);
    tbl[13] = mk(1, 12'h099, 0, 12'h000, 0, 0, 0,  0, 12'h000, 12'h000, 0, 0);
    tbl[14] = mk(1, 12'h0AA, 0, 12'h000, 0, 0, 0,  0, 12'h000, 12'h000, 0, 0);
    tbl[15] = mk(0, 12'h000, 0, 12'h000, 0, 0, 0,  1, 12'h55D, 12'h0AA, 0, 0);

    for (int i = 0; i < 16; i++) begin
      ch0_valid = tbl[i].v0; ch0_sample = tbl[i].s0;
      ch1_valid = tbl[i].v1; ch1_sample = tbl[i].s1;
      decim = tbl[i].dec; freeze = tbl[i].frz; clear_ovf = tbl[i].clr;
      step();
      check($sformatf("tbl%0d_en", i), 32'(wr_en), 32'(tbl[i].en));
      if (tbl[i].en) begin
        check($sformatf("tbl%0d_addr", i), 32'(wr_addr), 32'(tbl[i].addr));
        check($sformatf("tbl%0d_data", i), wr_data, 32'(tbl[i].data));
      end
      check($sformatf("tbl%0d_ovf", i), {30'd0, ch0_ovf, ch1_ovf}, {30'd0, tbl[i].ovf0, tbl[i].ovf1});
    end

    // Full ch0 sweep plus one sample past the wrap.
    do_reset();
    wraps = 0;
    for (int i = 0; i <= 320; i++) begin
      ch0_valid = 1; ch0_sample = 12'(i);
      step();
      if (ch0_wrap) begin
        wraps++;
        check("sweep_wrap_addr", 32'(wr_addr), 32'h698);
      end
    end
    idle();
    step();
    check("sweep_wrap_count", 32'(wraps), 1);
    check("sweep_321_en", 32'(wr_en), 1);
    check("sweep_321_addr", 32'(wr_addr), 32'h559);
    check("sweep_321_data", wr_data, 32'h140);

    // Decimate by 4 on ch1.
    do_reset();
    decim = 3;
    nw = 0;
    for (int i = 0; i < 40; i++) begin
      ch1_valid = 1; ch1_sample = 12'(i);
      step();
      if (wr_en) begin
        check("decim_addr", 32'(wr_addr), 32'h6AD + 32'(nw));
        check("decim_data", wr_data, 32'(4 * nw));
        nw++;
      end
    end
    idle();
    step();
    check("decim_writes", 32'(nw), 10);
    check("decim_ovf", 32'(ch1_ovf), 0);

    // Both channels every cycle: alternating grants, both overflow.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      ch0_valid = 1; ch0_sample = 12'h100 + 12'(i);
      ch1_valid = 1; ch1_sample = 12'h200 + 12'(i);
      step();
      if (i >= 1)
        check($sformatf("alt%0d_addr", i), 32'(wr_addr),
              (i % 2 == 1) ? 32'h559 + 32'((i - 1) / 2) : 32'h6AD + 32'((i - 2) / 2));
    end
    check("alt_ovf", {30'd0, ch0_ovf, ch1_ovf}, 32'b11);
    idle();
    clear_ovf = 1;
    step();
    check("alt_clr", {30'd0, ch0_ovf, ch1_ovf}, 0);

    // Freeze keeps the first held sample and the pointer.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      ch0_valid = 1; ch0_sample = 12'h010 + 12'(i);
      step();
    end
    idle();
    step();
    step();
    freeze = 1;
    for (int i = 0; i < 10; i++) begin
      ch0_valid = (i < 5); ch0_sample = 12'hA1 + 12'(i);
      step();
      check($sformatf("frz%0d_en", i), 32'(wr_en), 0);
    end
    check("frz_ovf", 32'(ch0_ovf), 1);
    idle();
    step();
    check("frz_resume_en", 32'(wr_en), 1);
    check("frz_resume_addr", 32'(wr_addr), 32'h55C);
    check("frz_resume_data", wr_data, 32'h0A1);

    // Overflow set wins over a simultaneous clear.
    do_reset();
    freeze = 1;
    ch0_valid = 1; ch0_sample = 12'h0B1;
    step();
    ch0_sample = 12'h0B2; clear_ovf = 1;
    step();
    check("setclr_ovf", 32'(ch0_ovf), 1);
    ch0_valid = 0;
    step();
    check("clr_ovf", 32'(ch0_ovf), 0);

    // Reset mid-sweep with a full hold.
    do_reset();
    for (int i = 0; i < 100; i++) begin
      ch0_valid = 1; ch0_sample = 12'(i);
      step();
    end
    idle();
    step();
    freeze = 1; ch0_valid = 1; ch0_sample = 12'hDEA;
    step();
    reset = 0;
    #1;
    model_reset();
    check("midrst_en", 32'(wr_en), 0);
    check("midrst_addr", 32'(wr_addr), 0);
    check("midrst_data", wr_data, 0);
    idle();
    @(posedge clock);
    #1;
    reset = 1;
    step();
    check("midrst_nostale", 32'(wr_en), 0);
    ch0_valid = 1; ch0_sample = 12'h0C3;
    step();
    idle();
    step();
    check("midrst_first_addr", 32'(wr_addr), 32'h559);
    check("midrst_first_data", wr_data, 32'h0C3);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      ch0_valid  = 1'($urandom_range(0, 1));
      ch1_valid  = 1'($urandom_range(0, 1));
      ch0_sample = 12'($urandom);
      ch1_sample = 12'($urandom);
      if ($urandom_range(0, 49) == 0) decim = 8'($urandom_range(0, 3));
      freeze    = ($urandom_range(0, 7) == 0);
      clear_ovf = ($urandom_range(0, 15) == 0);
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sig_capture_writer.md
Name: sig_capture_writer

Overview:
- Writer side of the waveform sample memory that the VGA display path reads through its sig_addr/sig_data port.
- Takes two 12-bit acquisition streams (ch0 = upper trace, ch1 = lower trace), decimates each one, and writes them as circular 320-entry sweeps.
- Ch0 occupies 0x559..0x698 and ch1 occupies 0x6AD..0x7EC, through the memory's single write port.
- Sits between the ADC/sample front end and the shared signal RAM, all in the 100 MHz system clock domain.

Parameters:
- CH0_BASE, 12'h559, base word address of the ch0 sweep
- CH1_BASE, 12'h6AD, base word address of the ch1 sweep
- DEPTH, 320, entries per sweep
- ADDR_WIDTH, 12, memory word address width
- DATA_WIDTH, 32, memory word width
- SAMPLE_WIDTH, 12, input sample width
- DECIM_WIDTH, 8, decimation control width

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- ch0_valid  in  1  ch0_sample is valid this cycle
- ch0_sample  in  SAMPLE_WIDTH  ch0 sample
- ch1_valid  in  1  ch1_sample is valid this cycle
- ch1_sample  in  SAMPLE_WIDTH  ch1 sample
- decim  in  DECIM_WIDTH  keep 1 of every decim+1 valid samples, applied to both channels
- freeze  in  1  while high, no memory writes are issued
- clear_ovf  in  1  clears both overflow flags
- wr_en  out  1  memory write strobe
- wr_addr  out  ADDR_WIDTH  memory write address
- wr_data  out  DATA_WIDTH  memory write data
- ch0_wrap  out  1  one-cycle pulse: ch0 sweep completed
- ch1_wrap  out  1  one-cycle pulse: ch1 sweep completed
- ch0_ovf  out  1  sticky: ch0 sample dropped
- ch1_ovf  out  1  sticky: ch1 sample dropped

Behaviour:
- Reset (async assert, sync-safe release): every output 0; pointers 0; decimation counters 0; hold registers empty; round-robin priority set to ch0.
- Decimation, per channel, on a valid sample:
  - counter==0: accept the sample and reload the counter with decim.
  - otherwise: decrement the counter and discard the sample.
  - decim==0 accepts every sample.
  - A change to decim takes effect at the next reload only.
  - The counter runs regardless of freeze.
- Hold register, per channel (one entry):
  - An accepted sample loads the hold register at the same edge.
  - Hold full and no grant this cycle: the new sample is dropped, the hold keeps its old value, and ovf is set.
  - Hold granted in the same cycle as a new accept: the hold reloads with the new sample and no overflow is flagged.
- Arbiter:
  - At most one write per cycle.
  - Grant goes to a full hold only when freeze=0.
  - Both full: grant the channel not granted last; after reset, ch0 wins.
  - A grant empties the hold (unless it reloads as above).
- Write outputs are registered. The edge after a grant drives:
  - wr_en=1
  - wr_addr=BASE+ptr
  - wr_data = zero-extended sample (bits 31:12 = 0)
- Latency:
  - valid sampled at edge N → hold at N → wr_en high after edge N+1, if uncontended and unfrozen.
  - Contended: at most 1 extra cycle.
- Pointer, per channel:
  - Range 0..DEPTH-1, increments on grant.
  - DEPTH-1 wraps to 0.
  - wrapN pulses in the same cycle as the wr_en that writes BASE+DEPTH-1.
  - Address arithmetic is done at ADDR_WIDTH; the configured bases never overflow.
- freeze:
  - Suppresses grants; wr_en is 0 from the next edge on.
  - Holds and pointers are retained, and writing resumes at the retained pointer when freeze falls.
- Overflow flags: clear_ovf clears both; if a set and a clear happen in the same cycle, set wins.
- wr_en is never high for two different addresses in one cycle. wr_addr and wr_data are don't-care when wr_en=0 but are held at their last value.

Decomposition:
- Package sig_capture_pkg: CH0_BASE, CH1_BASE, DEPTH, SAMPLE_WIDTH, DATA_WIDTH, ADDR_WIDTH constants. The display block shares these constants for its read addresses.
- Sub-module sig_channel_stage contains the decimation counter, hold register, overflow flag and sweep pointer, and generates the wrap flag. It is instantiated twice, with BASE as a parameter. The top level holds the round-robin arbiter and the output registers.

Test Plan:
- Reset, decim=0, ch0 only, samples 0x000..0x13F, one per cycle → 320 writes to 0x559..0x698 with data equal to the sample; ch0_wrap pulses exactly once, with wr_addr=0x698; the 321st sample lands at 0x559.
- decim=3, ch1 valid every cycle with a ramp → writes occur every 4th sample (0,4,8,…) at 0x6AD,0x6AE,…; ch1_ovf stays 0.
- ch0 and ch1 valid together every cycle, decim=0 → writes alternate ch0 (0x559), ch1 (0x6AD), ch0 (0x55A)…; ch0_ovf=1 and ch1_ovf=1 after the second cycle, because the holds stay full.
- freeze=1 for 10 cycles with ch0 valid 5 times (0xA1..0xA5), decim=0 → no wr_en; hold keeps 0xA1 and ch0_ovf=1; after freeze falls, the next write is 0xA1 at the retained pointer.
- clear_ovf asserted in the same cycle as a new overflow → ch0_ovf stays 1; clear_ovf alone → 0 next cycle.
- Reset asserted mid-sweep (ptr=100, hold full) → outputs 0 immediately; after release, the first write goes to CH0_BASE and the pre-reset hold is not written.
